mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency unified memory between instruction fetch and the memory-stage data path of the 5-stage core.
- Arbitrates between the two requesters and sequences each transaction through a req/ready handshake to memory.
- Returns read data with a one-cycle ack pulse; the pipeline stalls each requester while its req is high and its ack is low.
- Data requests have priority, and a streak counter guarantees fetch forward progress.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/arb_pick.sv | 39 +++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
// State codes, owner codes and the latched memory command bundle.
package mem_arb_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_IF_BUSY = 2'd1;
    localparam logic [1:0] ST_DM_BUSY = 2'd2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    typedef struct packed {
        logic              we;
        logic [STRB_W-1:0] wstrb;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
    } mem_cmd_t;

endpackage

// File: rtl/arb_pick.sv
// Fetch/data select with data priority and a bounded data streak.
// The streak only advances while fetch is actually waiting.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_DM_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_elig,
    input  logic dm_elig,
    input  logic if_req,
    input  logic grant,
    output logic pick_if,
    output logic pick_dm
);

    localparam logic [3:0] MAX = 4'(MAX_DM_STREAK);

    logic [3:0] streak;

    always_comb begin
        pick_if = if_elig && (!dm_elig || (streak == MAX));
        pick_dm = dm_elig && !pick_if;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            streak <= '0;
        end else if (grant) begin
            if (pick_if || !if_req) begin
                streak <= '0;
            end else if (streak != MAX) begin
                streak <= streak + 4'd1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and data access.
// Commands are latched at grant; completion or timeout pulses the owner's ack.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DM_STREAK  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    output logic [XLEN-1:0]   if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [STRB_W-1:0] dm_wstrb,
    input  logic [XLEN-1:0]   dm_addr,
    input  logic [XLEN-1:0]   dm_wdata,
    output logic [XLEN-1:0]   dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        owner,
    output logic              err
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic        TMO_EN   = (TIMEOUT_CYCLES != 0);

    logic [1:0]  state;
    logic [15:0] tmo_cnt;
    logic        if_elig;
    logic        dm_elig;
    logic        grant;
    logic        pick_if;
    logic        pick_dm;
    logic        timeout;
    mem_cmd_t    cmd;

    // A requester whose ack is out this cycle is still dropping req.
    assign if_elig = if_req && !if_ack;
    assign dm_elig = dm_req && !dm_ack;
    assign grant   = (state == ST_IDLE) && (if_elig || dm_elig);
    assign timeout = TMO_EN && (tmo_cnt == TMO_LAST);

    arb_pick #(
        .MAX_DM_STREAK(MAX_DM_STREAK)
    ) u_pick (
        .clk    (clk),
        .rst    (rst),
        .if_elig(if_elig),
        .dm_elig(dm_elig),
        .if_req (if_req),
        .grant  (grant),
        .pick_if(pick_if),
        .pick_dm(pick_dm)
    );

    always_comb begin
        cmd = '0;
        if (pick_dm) begin
            cmd.we    = dm_we;
            cmd.wstrb = dm_wstrb;
            cmd.addr  = dm_addr;
            cmd.wdata = dm_wdata;
        end else begin
            cmd.addr = if_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            err       <= 1'b0;
            owner     <= OWN_NONE;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        mem_req   <= 1'b1;
                        mem_we    <= cmd.we;
                        mem_wstrb <= cmd.wstrb;
                        mem_addr  <= cmd.addr;
                        mem_wdata <= cmd.wdata;
                        tmo_cnt   <= '0;
                        state     <= pick_if ? ST_IF_BUSY : ST_DM_BUSY;
                        owner     <= pick_if ? OWN_IF : OWN_DM;
                    end
                end
                ST_IF_BUSY, ST_DM_BUSY: begin
                    if (mem_ready || timeout) begin
                        mem_req <= 1'b0;
                        owner   <= OWN_NONE;
                        state   <= ST_IDLE;
                        err     <= !mem_ready;
                        if (state == ST_IF_BUSY) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_ready ? mem_rdata : '0;
                        end else begin
                            dm_ack <= 1'b1;
                            if (!mem_ready) begin
                                dm_rdata <= '0;
                            end else if (!mem_we) begin
                                dm_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter.
// A transaction-level reference model predicts grants and acks.
module tb_mem_port_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [3:0]  dm_wstrb = '0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [1:0]  owner;
    logic        err;

    mem_port_arbiter #(
        .MAX_DM_STREAK (MAXS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_wstrb (dm_wstrb),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ack   (dm_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_wstrb(mem_wstrb),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .owner    (owner),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          own;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        int          own;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } ack_t;

    grant_t gq[$];
    ack_t   aq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_on = 1'b0;

    // Reference model state
    int          m_own = 0;
    int          m_wait = 0;
    int          streak = 0;
    bit          m_we = 1'b0;
    bit          m_ack_if = 1'b0;
    bit          m_ack_dm = 1'b0;
    bit          n_if;
    bit          n_dm;
    bit          ie;
    bit          de;
    logic [31:0] exp_if_rd = '0;
    logic [31:0] exp_dm_rd = '0;

    // Memory environment controls
    bit force_stall = 1'b0;
    bit spur_en = 1'b0;
    bit spur_force = 1'b0;
    int lat = -1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %h want %h (cycle %0d)",
                         nm, act, exp, cyc);
        end
    endtask

    // Model: evaluates the cycle that ends at this edge.
    always @(posedge clk) begin
        if (!rst) begin
            m_own = 0;
            m_wait = 0;
            streak = 0;
            m_ack_if = 1'b0;
            m_ack_dm = 1'b0;
            exp_if_rd = '0;
            exp_dm_rd = '0;
            gq.delete();
            aq.delete();
        end else begin
            n_if = 1'b0;
            n_dm = 1'b0;
            if (m_own == 0) begin
                ie = if_req && !m_ack_if;
                de = dm_req && !m_ack_dm;
                if (ie && (!de || streak == MAXS)) begin
                    streak = 0;
                    gq.push_back('{own: 1, addr: if_addr, we: 1'b0,
                                   wstrb: 4'h0, wdata: 32'h0});
                    m_own = 1;
                    m_wait = 0;
                    m_we = 1'b0;
                end else if (de) begin
                    streak = if_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
                    gq.push_back('{own: 2, addr: dm_addr, we: dm_we,
                                   wstrb: dm_wstrb, wdata: dm_wdata});
                    m_own = 2;
                    m_wait = 0;
                    m_we = dm_we;
                end
            end else begin
                m_wait++;
                if (mem_ready || m_wait == TMO) begin
                    if (m_own == 1) begin
                        exp_if_rd = mem_ready ? mem_rdata : 32'h0;
                        n_if = 1'b1;
                        aq.push_back('{own: 1, rdata: exp_if_rd,
                                       err: !mem_ready, due: cyc + 1});
                    end else begin
                        if (!mem_ready) exp_dm_rd = 32'h0;
                        else if (!m_we) exp_dm_rd = mem_rdata;
                        n_dm = 1'b1;
                        aq.push_back('{own: 2, rdata: exp_dm_rd,
                                       err: !mem_ready, due: cyc + 1});
                    end
                    m_own = 0;
                end
            end
            m_ack_if = n_if;
            m_ack_dm = n_dm;
        end
        cyc++;
    end

    // Monitor / scoreboard
    grant_t cur;
    bit     cur_valid = 1'b0;
    ack_t   ea;
    bit     e_if;
    bit     e_dm;
    bit     e_err;

    always @(negedge clk) begin
        if (mon_on) begin
            e_if = 1'b0;
            e_dm = 1'b0;
            e_err = 1'b0;
            if (aq.size() > 0 && aq[0].due == cyc) begin
                ea = aq.pop_front();
                e_err = ea.err;
                if (ea.own == 1) begin
                    e_if = 1'b1;
                    chk("if_rdata", if_rdata, ea.rdata);
                end else begin
                    e_dm = 1'b1;
                    chk("dm_rdata", dm_rdata, ea.rdata);
                end
            end
            chk("if_ack", 32'(if_ack), 32'(e_if));
            chk("dm_ack", 32'(dm_ack), 32'(e_dm));
            chk("err", 32'(err), 32'(e_err));
            chk("mem_req", 32'(mem_req), 32'(m_own != 0));
            chk("owner", 32'(owner), 32'(m_own));
            if (m_own != 0) begin
                if (!cur_valid) begin
                    if (gq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL grant_q: got empty want entry (cycle %0d)", cyc);
                    end else begin
                        cur = gq.pop_front();
                        cur_valid = 1'b1;
                    end
                end
                if (cur_valid) begin
                    chk("mem_addr", mem_addr, cur.addr);
                    chk("mem_we", 32'(mem_we), 32'(cur.we));
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
                    if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                end
            end else begin
                cur_valid = 1'b0;
            end
        end
    end

    // Memory responder
    always @(posedge clk) begin
        #2;
        mem_ready = 1'b0;
        if (mem_req) begin
            if (lat < 0) begin
                if (force_stall || $urandom_range(0, 29) == 0) lat = 1 << 20;
                else lat = int'($urandom_range(0, 4));
            end
            if (lat == 0) begin
                mem_ready = 1'b1;
                mem_rdata = $urandom();
                lat = -1;
            end else begin
                lat--;
            end
        end else begin
            lat = -1;
            if (spur_force || (spur_en && $urandom_range(0, 3) == 0)) begin
                mem_ready = 1'b1;
                mem_rdata = $urandom();
            end
        end
    end

    logic [3:0] strbs [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

    task automatic new_dm();
        dm_req = 1'b1;
        dm_we = 1'($urandom_range(0, 1));
        dm_wstrb = strbs[$urandom_range(0, 6)];
        dm_addr = $urandom();
        dm_wdata = $urandom();
    endtask

    task automatic drive_if(input bit allow_new);
        if (if_req) begin
            if (if_ack) begin
                if (allow_new && $urandom_range(0, 1) == 1) if_addr = $urandom() & 32'hFFFF_FFFC;
                else if_req = 1'b0;
            end
        end else if (allow_new && $urandom_range(0, 2) == 0) begin
            if_req = 1'b1;
            if_addr = $urandom() & 32'hFFFF_FFFC;
        end else begin
            if_addr = $urandom();
        end
    endtask

    task automatic drive_dm(input bit allow_new);
        if (dm_req) begin
            if (dm_ack) begin
                if (allow_new && $urandom_range(0, 1) == 1) new_dm();
                else dm_req = 1'b0;
            end
        end else if (allow_new && $urandom_range(0, 2) == 0) begin
            new_dm();
        end else begin
            dm_addr = $urandom();
            dm_wdata = $urandom();
            dm_we = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_ack(input bit is_if, input int lim, output int busy_n);
        busy_n = 0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk);
            #1;
            if (mem_req) busy_n++;
            if (is_if ? if_ack : dm_ack) return;
        end
        total++;
        bad++;
        $display("FAIL ack_wait: got no ack want ack within %0d cycles", lim);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'h0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
        chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_if_ack"}, 32'(if_ack), 32'h0);
        chk({tag, "_dm_ack"}, 32'(dm_ack), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_owner"}, 32'(owner), 32'h0);
        chk({tag, "_if_rdata"}, if_rdata, 32'h0);
        chk({tag, "_dm_rdata"}, dm_rdata, 32'h0);
    endtask

    int n;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;
        mon_on = 1'b1;
        spur_en = 1'b1;

        repeat (3000) begin
            @(posedge clk);
            #1;
            drive_if(1'b1);
            drive_dm(1'b1);
        end

        n = 0;
        while ((if_req || dm_req || mem_req) && n < 1000) begin
            @(posedge clk);
            #1;
            drive_if(1'b0);
            drive_dm(1'b0);
            n++;
        end
        chk("drain", 32'(if_req || dm_req || mem_req), 32'h0);

        // Load that never completes: expect timeout after 64 busy cycles.
        force_stall = 1'b1;
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_wstrb = 4'hF;
        dm_addr = 32'h0000_3000;
        wait_ack(1'b0, 200, n);
        chk("to_len", n, 32'd64);
        chk("to_err", 32'(err), 32'h1);
        chk("to_rdata", dm_rdata, 32'h0);
        dm_req = 1'b0;
        force_stall = 1'b0;

        @(posedge clk);
        #1;
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_wstrb = 4'hF;
        dm_addr = 32'h0000_2000;
        dm_wdata = 32'hDEAD_BEEF;
        wait_ack(1'b0, 200, n);
        chk("after_to_err", 32'(err), 32'h0);
        dm_req = 1'b0;

        @(posedge clk);
        #1;
        if_req = 1'b1;
        if_addr = 32'h0000_0100;
        wait_ack(1'b1, 200, n);
        if_req = 1'b0;

        // Reset while a data access is outstanding.
        @(posedge clk);
        #1;
        force_stall = 1'b1;
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 32'h0000_4000;
        n = 0;
        while (!(mem_req && owner == 2'd2) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_busy", 32'(owner), 32'h2);
        rst = 1'b0;
        dm_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        force_stall = 1'b0;
        check_zero("midrst");
        @(posedge clk);
        #1;
        spur_force = 1'b1;
        @(posedge clk);
        #1;
        spur_force = 1'b0;
        chk("late_ready_dm_ack", 32'(dm_ack), 32'h0);
        chk("late_ready_mem_req", 32'(mem_req), 32'h0);
        if_req = 1'b1;
        if_addr = 32'h0000_0100;
        wait_ack(1'b1, 200, n);
        if_req = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        chk("end_aq", aq.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
